// File: rtl/led_fade_sequencer.sv
// ============================================================================
// Module      : led_fade_sequencer
// Description : Triangular 0->255->0 duty fade with dwell at the extremes,
//               offered to the PWM stage over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_fade_sequencer #(
    parameter int PRESCALE   = 256,
    parameter int STEP       = 1,
    parameter int HOLD_STEPS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [7:0] duty,
    output logic       duty_valid,
    input  logic       duty_ready,
    output logic [2:0] phase,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam int              PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [8:0]      STEP9      = 9'(STEP);
    localparam logic [7:0]      HOLD8      = 8'(HOLD_STEPS);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      duty_q, duty_d;
    logic            duty_valid_q, duty_valid_d;
    logic            overrun_q, overrun_d;

    logic            tick;
    logic            blocked;
    logic [8:0]      rise_sum;
    logic [7:0]      rise_val;
    logic [7:0]      fall_val;

    assign tick     = enable && (state_q != IDLE) && (presc_q == PRESC_LAST);
    assign blocked  = duty_valid_q && !duty_ready;
    assign rise_sum = {1'b0, duty_q} + STEP9;
    assign rise_val = rise_sum[8] ? 8'hFF : rise_sum[7:0];
    assign fall_val = ({1'b0, duty_q} <= STEP9) ? 8'h00 : (duty_q - STEP9[7:0]);

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        hold_d       = hold_q;
        duty_d       = duty_q;
        duty_valid_d = duty_valid_q;
        overrun_d    = overrun_q;

        // Acceptance completes even while disabled; a coincident ramp tick
        // below re-raises valid with the new value.
        if (duty_valid_q && duty_ready) begin
            duty_valid_d = 1'b0;
        end

        if (state_q == IDLE) begin
            if (enable) begin
                state_d = RISE;
                presc_d = '0;
            end
        end else if (enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (tick) begin
            case (state_q)
                RISE: begin
                    if (blocked) begin
                        overrun_d = 1'b1;
                    end else begin
                        duty_d       = rise_val;
                        duty_valid_d = 1'b1;
                        if (rise_val == 8'hFF) begin
                            state_d = HOLD_HI;
                            hold_d  = HOLD8;
                        end
                    end
                end
                FALL: begin
                    if (blocked) begin
                        overrun_d = 1'b1;
                    end else begin
                        duty_d       = fall_val;
                        duty_valid_d = 1'b1;
                        if (fall_val == 8'h00) begin
                            state_d = HOLD_LO;
                            hold_d  = HOLD8;
                        end
                    end
                end
                HOLD_HI: begin
                    if (hold_q == 8'd0) state_d = FALL;
                    else                hold_d  = hold_q - 8'd1;
                end
                HOLD_LO: begin
                    if (hold_q == 8'd0) state_d = RISE;
                    else                hold_d  = hold_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            hold_q       <= 8'd0;
            duty_q       <= 8'd0;
            duty_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            hold_q       <= hold_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = duty_valid_q;
    assign phase      = state_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_led_fade_sequencer.sv
// ============================================================================
// Module      : tb_led_fade_sequencer
// Description : Directed self-checking bench for led_fade_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_fade_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: PRESCALE=4, STEP=64, HOLD_STEPS=1
    logic       rst_a, en_a, rdy_a;
    logic [7:0] duty_a;
    logic       val_a, ovr_a;
    logic [2:0] ph_a;

    // Instance B: PRESCALE=4, STEP=100, HOLD_STEPS=0
    logic       rst_b, en_b, rdy_b;
    logic [7:0] duty_b;
    logic       val_b, ovr_b;
    logic [2:0] ph_b;

    int checks   = 0;
    int failures = 0;

    led_fade_sequencer #(.PRESCALE(4), .STEP(64), .HOLD_STEPS(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a),
        .duty(duty_a), .duty_valid(val_a), .duty_ready(rdy_a),
        .phase(ph_a), .overrun(ovr_a)
    );

    led_fade_sequencer #(.PRESCALE(4), .STEP(100), .HOLD_STEPS(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b),
        .duty(duty_b), .duty_valid(val_b), .duty_ready(rdy_b),
        .phase(ph_b), .overrun(ovr_b)
    );

    task automatic reset_a();
        rst_a = 1'b1; en_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b0; rdy_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        checks++;
        if (duty_a !== 8'd0 || val_a !== 1'b0 || ph_a !== 3'd0 || ovr_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: duty=%0d valid=%b phase=%0d overrun=%b required 0/0/0/0",
                     duty_a, val_a, ph_a, ovr_a);
        end
        checks++;
        if (duty_b !== 8'd0 || val_b !== 1'b0 || ph_b !== 3'd0 || ovr_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: duty=%0d valid=%b phase=%0d overrun=%b required 0/0/0/0",
                     duty_b, val_b, ph_b, ovr_b);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (ph_a !== 3'd0 || val_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_wait: phase=%0d valid=%b required 0/0", ph_a, val_a);
        end
    endtask

    // Full triangle with hold: emissions and extreme-phase timing.
    task automatic test_sequence();
        int ek [9] = '{4, 8, 12, 16, 28, 32, 36, 40, 52};
        int ed [9] = '{64, 128, 192, 255, 191, 127, 63, 0, 64};
        int idx = 0;
        logic exp_v;
        reset_a();
        rdy_a = 1'b1;
        en_a  = 1'b1;
        for (int k = 0; k <= 52; k++) begin
            @(posedge clk); #1;
            exp_v = (idx < 9) && (k == ek[idx]);
            checks++;
            if (val_a !== exp_v) begin
                failures++;
                $display("FAIL seq_valid k=%0d: valid=%b required %b", k, val_a, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (duty_a !== 8'(ed[idx])) begin
                    failures++;
                    $display("FAIL seq_duty k=%0d: duty=%0d required %0d", k, duty_a, ed[idx]);
                end
                idx++;
            end
            if (k == 16 || k == 23 || k == 24 || k == 40 || k == 47 || k == 48) begin
                checks++;
                if (ph_a !== ((k == 16 || k == 23) ? 3'd2 : (k == 24) ? 3'd3 :
                              (k == 48) ? 3'd1 : 3'd4)) begin
                    failures++;
                    $display("FAIL seq_phase k=%0d: phase=%0d", k, ph_a);
                end
            end
        end
        checks++;
        if (ovr_a !== 1'b0) begin
            failures++;
            $display("FAIL seq_overrun: overrun=%b required 0", ovr_a);
        end
    endtask

    // Saturating rise and fall with a large step.
    task automatic test_saturation();
        int ek [7] = '{4, 8, 12, 20, 24, 28, 36};
        int ed [7] = '{100, 200, 255, 155, 55, 0, 100};
        int idx = 0;
        logic exp_v;
        rdy_b = 1'b1;
        en_b  = 1'b1;
        for (int k = 0; k <= 36; k++) begin
            @(posedge clk); #1;
            exp_v = (idx < 7) && (k == ek[idx]);
            checks++;
            if (val_b !== exp_v) begin
                failures++;
                $display("FAIL sat_valid k=%0d: valid=%b required %b", k, val_b, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (duty_b !== 8'(ed[idx])) begin
                    failures++;
                    $display("FAIL sat_duty k=%0d: duty=%0d required %0d", k, duty_b, ed[idx]);
                end
                idx++;
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_backpressure();
        reset_a();
        rdy_a = 1'b0;
        en_a  = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin
                checks++;
                if (val_a !== 1'b1 || duty_a !== 8'd64) begin
                    failures++;
                    $display("FAIL bp_first: valid=%b duty=%0d required 1/64", val_a, duty_a);
                end
            end
            if (k == 9) begin
                checks++;
                if (val_a !== 1'b1 || duty_a !== 8'd64 || ovr_a !== 1'b1 || ph_a !== 3'd1) begin
                    failures++;
                    $display("FAIL bp_stall: valid=%b duty=%0d overrun=%b phase=%0d required 1/64/1/1",
                             val_a, duty_a, ovr_a, ph_a);
                end
                rdy_a = 1'b1;
            end
            if (k == 11) begin
                checks++;
                if (val_a !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_accept: valid=%b required 0", val_a);
                end
            end
            if (k == 12) begin
                checks++;
                if (val_a !== 1'b1 || duty_a !== 8'd128 || ovr_a !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_resume: valid=%b duty=%0d overrun=%b required 1/128/1",
                             val_a, duty_a, ovr_a);
                end
            end
        end
    endtask

    // Accept coincides with a ramp tick: valid never drops.
    task automatic test_back_to_back();
        reset_a();
        rdy_a = 1'b0;
        en_a  = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            if (k >= 4) begin
                checks++;
                if (val_a !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_valid k=%0d: valid=%b required 1", k, val_a);
                end
            end
            if (k == 7) rdy_a = 1'b1;
            if (k == 8) begin
                rdy_a = 1'b0;
                checks++;
                if (duty_a !== 8'd128) begin
                    failures++;
                    $display("FAIL b2b_duty: duty=%0d required 128", duty_a);
                end
            end
        end
        checks++;
        if (ovr_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overrun: overrun=%b required 0", ovr_a);
        end
    endtask

    // Ten disabled cycles delay the next emission by exactly ten cycles.
    task automatic test_enable_freeze();
        int ek [3] = '{4, 18, 22};
        int ed [3] = '{64, 128, 192};
        int idx = 0;
        logic exp_v;
        reset_a();
        rdy_a = 1'b1;
        en_a  = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            @(posedge clk); #1;
            exp_v = (idx < 3) && (k == ek[idx]);
            checks++;
            if (val_a !== exp_v) begin
                failures++;
                $display("FAIL frz_valid k=%0d: valid=%b required %b", k, val_a, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (duty_a !== 8'(ed[idx])) begin
                    failures++;
                    $display("FAIL frz_duty k=%0d: duty=%0d required %0d", k, duty_a, ed[idx]);
                end
                idx++;
            end
            if (k == 4)  en_a = 1'b0;
            if (k == 14) en_a = 1'b1;
        end
    endtask

    task automatic test_rst_mid_fall();
        reset_a();
        rdy_a = 1'b0;
        en_a  = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            @(posedge clk); #1;
            if (k == 9) rdy_a = 1'b1;
        end
        checks++;
        if (val_a !== 1'b1 || duty_a !== 8'd191 || ph_a !== 3'd3 || ovr_a !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: valid=%b duty=%0d phase=%0d overrun=%b required 1/191/3/1",
                     val_a, duty_a, ph_a, ovr_a);
        end
        rdy_a = 1'b0;
        rst_a = 1'b1;
        en_a  = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b0;
        checks++;
        if (val_a !== 1'b0 || duty_a !== 8'd0 || ph_a !== 3'd0 || ovr_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: valid=%b duty=%0d phase=%0d overrun=%b required 0/0/0/0",
                     val_a, duty_a, ph_a, ovr_a);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (ph_a !== 3'd0 || val_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait: phase=%0d valid=%b required 0/0", ph_a, val_a);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_enable_freeze();
        test_rst_mid_fall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
